// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared state encoding and default constants for the DLX fetch controller.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

package inst_fetch_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_DBG_WAIT_MAX = 4;
  localparam logic [31:0] DEF_RESET_PC     = 32'd0;
  localparam logic [31:0] DEF_LAST_PC      = 32'd31;
  localparam logic [31:0] DLX_NOP          = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the instruction ROM read port between fetch and a debug reader.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module rom_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DBG_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              port_busy,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              dbg_grant,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned CNT_W = (DBG_WAIT_MAX > 0) ? $clog2(DBG_WAIT_MAX + 1) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             forced;

  assign forced    = (wait_cnt == CNT_W'(DBG_WAIT_MAX));
  // No back-to-back grants: the ack cycle gives the requester a chance to drop its request.
  assign dbg_grant = !rst && dbg_req && !dbg_ack && (!port_busy || forced);
  assign rom_addr  = dbg_grant ? dbg_addr : fetch_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      dbg_ack  <= 1'b0;
      dbg_data <= '0;
    end else begin
      dbg_ack <= dbg_grant;
      if (dbg_grant) begin
        dbg_data <= rom_data;
        wait_cnt <= '0;
      end else if (!dbg_req) begin
        wait_cnt <= '0;
      end else if (port_busy && !forced) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: DLX instruction fetch with PC, output slot, redirect and HALT.
// Optional debug ROM reader enabled by INST_FETCH_DBG_PORT_EN. Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = DEF_ADDR_W,
  parameter int unsigned       DATA_W       = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] LAST_PC      = ADDR_W'(DEF_LAST_PC),
  parameter int unsigned       DBG_WAIT_MAX = DEF_DBG_WAIT_MAX
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              halt_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              slot_free;
  logic              port_busy;
  logic              dbg_grant;
  logic              fetch;

  assign slot_free = !inst_valid_o || inst_ready_i;
  // The port is "busy" exactly when fetch would want it this cycle.
  assign port_busy = (state_q == ST_RUN) && slot_free && !redirect_i;
  assign fetch     = port_busy && !dbg_grant;
  assign halt_o    = (state_q == ST_HALT);

`ifdef INST_FETCH_DBG_PORT_EN
  rom_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DBG_WAIT_MAX (DBG_WAIT_MAX)
  ) u_arb (
    .clk        (clk_i),
    .rst        (reset_i),
    .port_busy  (port_busy),
    .fetch_addr (pc_q),
    .dbg_req    (dbg_req_i),
    .dbg_addr   (dbg_addr_i),
    .rom_data   (rom_data_i),
    .rom_addr   (rom_addr_o),
    .dbg_grant  (dbg_grant),
    .dbg_ack    (dbg_ack_o),
    .dbg_data   (dbg_data_o)
  );
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req_i, dbg_addr_i};
  assign rom_addr_o = pc_q;
  assign dbg_grant  = 1'b0;
  assign dbg_ack_o  = 1'b0;
  assign dbg_data_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = ST_RUN;
    end else if (fetch && (pc_q == LAST_PC)) begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q         <= RESET_PC;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
    end else if (redirect_i) begin
      pc_q         <= redirect_pc_i;
      inst_valid_o <= 1'b0;
    end else if (fetch) begin
      inst_o       <= rom_data_i;
      inst_pc_o    <= pc_q;
      inst_valid_o <= 1'b1;
      pc_q         <= pc_q + ADDR_W'(1);
    end else if (slot_free) begin
      inst_valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire
